pack_loader_ctrl: RTL and testbench

//  Framing and sequencing controller between the UART receiver/transmitter and diff_freq_serial_out.
//  - Collects a framed command: SOF, PACK_NUM payload bytes, XOR checksum.
//  - Buffers and validates the frame.
//  - Replays the payload to the serial-out engine only once the engine is idle.
//  - Answers the host with ACK or NAK over UART TX.

---
 rtl/pack_loader_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_pack_loader_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_loader_ctrl.sv
// pack_loader_ctrl
// Takes a framed command from the UART receiver: SOF, PACK_NUM payload bytes,
// then an XOR checksum. A good frame is buffered and replayed byte by byte into
// the diff_freq_serial_out engine once that engine is idle. The host gets ACK
// or NAK back over UART TX.
//
// Strobe semantics: every *_tick and o_tx_start is a single-cycle valid pulse.
// There is no ready/backpressure. A receiver must take the data in the cycle
// the strobe is high. i_rx_data is only meaningful while i_rx_done_tick is high.
// o_data is meaningful while o_data_tick is high and keeps its value between
// ticks. o_tx_data is valid from o_tx_start until the i_tx_done_tick that
// returns the FSM to IDLE.
// o_dbg_state shows the FSM state encoding (S_* below) so external checkers can
// follow it.

module pack_loader_ctrl #(
  parameter int         DATA_BIT = 32,
  parameter int         PACK_NUM = (DATA_BIT / 8) * 2 + 1,
  parameter logic [7:0] SOF      = 8'hA5,
  parameter logic [7:0] ACK      = 8'h06,
  parameter logic [7:0] NAK      = 8'h15,
  parameter int         TIMEOUT  = 100000,
  parameter int         TO_BIT   = 17,
  parameter int         GAP      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_done_tick,
  input  logic        i_done_tick,
  output logic [7:0]  o_data,
  output logic        o_data_tick,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done_tick,
  output logic        o_busy,
  output logic [15:0] o_pack_cnt,
  output logic [7:0]  o_err_cnt,
  output logic [2:0]  o_dbg_state
);

  localparam int IDX_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int GAP_W = $clog2(GAP + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PACK_NUM - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP);
  localparam logic [TO_BIT-1:0] TO_END   = TO_BIT'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_WAIT_ENG = 3'd3;
  localparam logic [2:0] S_REPLAY   = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  logic [2:0]        state_q,     state_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [7:0]        csum_q,      csum_d;
  logic [TO_BIT-1:0] to_cnt_q,    to_cnt_d;
  logic [IDX_W-1:0]  ridx_q,      ridx_d;
  logic [GAP_W-1:0]  gap_q,       gap_d;
  logic              eng_busy_q,  eng_busy_d;
  logic [7:0]        data_q,      data_d;
  logic              data_tick_q, data_tick_d;
  logic              tx_start_q,  tx_start_d;
  logic [7:0]        tx_data_q,   tx_data_d;
  logic [15:0]       pack_cnt_q,  pack_cnt_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;
  logic [7:0]        buf_q [PACK_NUM];
  logic [7:0]        buf_d [PACK_NUM];

  logic              err_inc;
  logic              eng_set;
  logic              to_expired;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  ridx_nxt;

  assign idx_nxt    = idx_q + 1'b1;
  assign ridx_nxt   = ridx_q + 1'b1;
  assign to_expired = (to_cnt_q == TO_END);

  // Next-state logic: FSM, buffer writes, replay pacing, timeout and counters.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    to_cnt_d    = '0;
    ridx_d      = ridx_q;
    gap_d       = gap_q;
    data_d      = data_q;
    data_tick_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    pack_cnt_d  = pack_cnt_q;
    buf_d       = buf_q;
    err_inc     = 1'b0;
    eng_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_done_tick && (i_rx_data == SOF)) begin
          state_d = S_COLLECT;
          idx_d   = '0;
          csum_d  = 8'h00;
        end
      end

      S_COLLECT: begin
        if (i_rx_done_tick) begin
          buf_d[idx_q] = i_rx_data;
          csum_d       = csum_q ^ i_rx_data;
          idx_d        = idx_nxt;
          if (idx_q == LAST_IDX) begin
            state_d = S_CHECK;
          end
        end else if (to_expired) begin
          state_d    = S_RESP;
          tx_start_d = 1'b1;
          tx_data_d  = NAK;
          err_inc    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (i_rx_done_tick) begin
          if (i_rx_data == csum_q) begin
            state_d = S_WAIT_ENG;
          end else begin
            state_d    = S_RESP;
            tx_start_d = 1'b1;
            tx_data_d  = NAK;
            err_inc    = 1'b1;
          end
        end else if (to_expired) begin
          state_d    = S_RESP;
          tx_start_d = 1'b1;
          tx_data_d  = NAK;
          err_inc    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_WAIT_ENG: begin
        // Bytes arriving while a frame is pending are an overrun. They are dropped.
        if (i_rx_done_tick) begin
          err_inc = 1'b1;
        end
        if (!eng_busy_q) begin
          state_d     = S_REPLAY;
          ridx_d      = '0;
          gap_d       = '0;
          data_d      = buf_q[0];
          data_tick_d = 1'b1;
        end
      end

      S_REPLAY: begin
        if (i_rx_done_tick) begin
          err_inc = 1'b1;
        end
        // gap_q == 0 marks the cycle in which the tick for buf[ridx] is on the output.
        if ((gap_q == '0) && (ridx_q == LAST_IDX)) begin
          state_d    = S_RESP;
          eng_set    = 1'b1;
          pack_cnt_d = pack_cnt_q + 16'd1;
          tx_start_d = 1'b1;
          tx_data_d  = ACK;
        end else if (gap_q == GAP_END) begin
          gap_d       = '0;
          ridx_d      = ridx_nxt;
          data_d      = buf_q[ridx_nxt];
          data_tick_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_RESP: begin
        if (i_rx_done_tick) begin
          err_inc = 1'b1;
        end
        if (i_tx_done_tick) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Engine occupancy. Setting it at the end of a replay wins over a coincident done.
  always_comb begin
    eng_busy_d = eng_set | (eng_busy_q & ~i_done_tick);
  end

  // Error counter: at most one increment per cycle, holds at 8'hFF once reached.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      to_cnt_q    <= '0;
      ridx_q      <= '0;
      gap_q       <= '0;
      eng_busy_q  <= 1'b0;
      data_q      <= 8'h00;
      data_tick_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      pack_cnt_q  <= 16'h0000;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      to_cnt_q    <= to_cnt_d;
      ridx_q      <= ridx_d;
      gap_q       <= gap_d;
      eng_busy_q  <= eng_busy_d;
      data_q      <= data_d;
      data_tick_q <= data_tick_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      pack_cnt_q  <= pack_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Payload buffer. Its contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign o_data      = data_q;
  assign o_data_tick = data_tick_q;
  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_pack_cnt  = pack_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pack_loader_ctrl.sv
// tb_pack_loader_ctrl: directed stimulus for pack_loader_ctrl. A scoreboard
// holds the expected replay bytes and response bytes. A negedge monitor checks
// each DUT output event against it.

module tb_pack_loader_ctrl;

  localparam int         PACK_NUM = 9;
  localparam int         TIMEOUT  = 40;
  localparam int         TO_BIT   = 6;
  localparam int         GAP      = 3;
  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd3;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_tick;
  logic        done_tick;
  logic [7:0]  o_data;
  logic        o_data_tick;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        tx_done;
  logic        o_busy;
  logic [15:0] o_pack_cnt;
  logic [7:0]  o_err_cnt;
  logic [2:0]  o_dbg_state;

  pack_loader_ctrl #(
    .DATA_BIT (32),
    .PACK_NUM (PACK_NUM),
    .SOF      (SOF),
    .ACK      (ACK),
    .NAK      (NAK),
    .TIMEOUT  (TIMEOUT),
    .TO_BIT   (TO_BIT),
    .GAP      (GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_data      (rx_data),
    .i_rx_done_tick (rx_tick),
    .i_done_tick    (done_tick),
    .o_data         (o_data),
    .o_data_tick    (o_data_tick),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (tx_done),
    .o_busy         (o_busy),
    .o_pack_cnt     (o_pack_cnt),
    .o_err_cnt      (o_err_cnt),
    .o_dbg_state    (o_dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] pl [PACK_NUM];

  int n_ticks = 0;
  int tx_cnt = 0;
  int tx_served = 0;
  int last_tick_cyc = 0;
  int first_tick_cyc = 0;
  int tx_cyc = 0;
  int sent_cyc = 0;
  int cs_cyc = 0;
  int done_cyc = 0;
  int exp_err = 0;
  int exp_pack = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every replayed byte and response byte with the scoreboard
  always @(negedge clk) begin
    if (o_data_tick) begin
      if ((n_ticks % PACK_NUM) == 0) first_tick_cyc = cyc;
      else check("tick_spacing", cyc - last_tick_cyc, GAP + 1);
      last_tick_cyc = cyc;
      check("data_q_empty_on_tick", exp_data_q.size() == 0, 0);
      if (exp_data_q.size() > 0) check("o_data", o_data, exp_data_q.pop_front());
      n_ticks++;
    end
    if (o_tx_start) begin
      tx_cyc = cyc;
      check("tx_q_empty_on_start", exp_tx_q.size() == 0, 0);
      if (exp_tx_q.size() > 0) check("o_tx_data", o_tx_data, exp_tx_q.pop_front());
      tx_cnt++;
    end
  end

  // Driver tasks (all start and end 1 time unit after a rising edge)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_tick  = 1'b1;
    sent_cyc = cyc;
    step(1);
    rx_tick  = 1'b0;
  endtask

  task automatic pulse_done();
    done_tick = 1'b1;
    done_cyc  = cyc;
    step(1);
    done_tick = 1'b0;
  endtask

  function automatic logic [7:0] calc_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < PACK_NUM; i++) c = c ^ pl[i];
    return c;
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < PACK_NUM; i++) pl[i] = 8'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < PACK_NUM; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] cs, input bit good);
    if (good) begin
      for (int i = 0; i < PACK_NUM; i++) exp_data_q.push_back(pl[i]);
      exp_tx_q.push_back(ACK);
    end else begin
      exp_tx_q.push_back(NAK);
    end
    send_byte(SOF);
    for (int i = 0; i < PACK_NUM; i++) begin
      send_byte(pl[i]);
      step($urandom_range(0, 2));
    end
    send_byte(cs);
    cs_cyc = sent_cyc;
  endtask

  task automatic serve_tx(input int limit);
    int k;
    k = 0;
    while ((tx_cnt == tx_served) && (k < limit)) begin
      step(1);
      k++;
    end
    check("tx_seen", tx_cnt != tx_served, 1);
    if (tx_cnt != tx_served) begin
      tx_served++;
      tx_done = 1'b1;
      step(1);
      tx_done = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_o_data"},      o_data,      0);
    check({tag, "_o_data_tick"}, o_data_tick, 0);
    check({tag, "_o_tx_start"},  o_tx_start,  0);
    check({tag, "_o_tx_data"},   o_tx_data,   0);
    check({tag, "_o_busy"},      o_busy,      0);
    check({tag, "_o_pack_cnt"},  o_pack_cnt,  0);
    check({tag, "_o_err_cnt"},   o_err_cnt,   0);
  endtask

  // Directed sequence
  initial begin
    int base;
    int k;
    rst = 1'b1; rx_data = 8'h00; rx_tick = 1'b0; done_tick = 1'b0; tx_done = 1'b0;
    step(3);
    check_zero_outputs("reset");
    check("reset_state", o_dbg_state, ST_IDLE);
    rst = 1'b0;
    step(2);

    // 1: good frame 01..09, checksum 01
    fill_seq();
    check("t1_csum_model", calc_csum(), 8'h01);
    send_frame(8'h01, 1'b1);
    serve_tx(200);
    exp_pack++;
    check("t1_first_tick_latency", first_tick_cyc - cs_cyc, 2);
    check("t1_pack_cnt", o_pack_cnt, exp_pack);
    check("t1_err_cnt", o_err_cnt, exp_err);
    check("t1_o_data_hold", o_data, 8'h09);
    check("t1_idle", o_busy, 0);
    pulse_done();

    // 2: bad checksum, then a good frame is still accepted
    base = n_ticks;
    send_frame(8'h00, 1'b0);
    serve_tx(200);
    exp_err++;
    check("t2_no_replay", n_ticks, base);
    check("t2_err_cnt", o_err_cnt, exp_err);
    check("t2_pack_cnt", o_pack_cnt, exp_pack);
    fill_rand();
    send_frame(calc_csum(), 1'b1);
    serve_tx(200);
    exp_pack++;
    check("t2_good_pack_cnt", o_pack_cnt, exp_pack);
    check("t2_good_latency", first_tick_cyc - cs_cyc, 2);
    pulse_done();

    // 3: timeout after three payload bytes
    exp_tx_q.push_back(NAK);
    base = n_ticks;
    send_byte(SOF);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    serve_tx(200);
    exp_err++;
    check("t3_timeout_latency", tx_cyc - sent_cyc, TIMEOUT + 1);
    check("t3_err_cnt", o_err_cnt, exp_err);
    check("t3_state_idle", o_dbg_state, ST_IDLE);
    check("t3_no_replay", n_ticks, base);

    // 4: frame A leaves the engine busy, frame B waits for i_done_tick
    fill_rand();
    send_frame(calc_csum(), 1'b1);
    serve_tx(200);
    exp_pack++;
    fill_rand();
    base = n_ticks;
    send_frame(calc_csum(), 1'b1);
    step(20);
    check("t4_stall_no_tick", n_ticks, base);
    check("t4_stall_state", o_dbg_state, ST_WAIT);
    check("t4_stall_busy", o_busy, 1);
    check("t4_stall_no_tx", tx_cnt, tx_served);
    pulse_done();
    // i_done_tick together with B's last byte: the engine must stay busy
    k = 0;
    while (!(o_data_tick && ((n_ticks % PACK_NUM) == PACK_NUM - 1)) && (k < 200)) begin
      step(1);
      k++;
    end
    check("t4_last_tick_found", k < 200, 1);
    done_tick = 1'b1;
    step(1);
    done_tick = 1'b0;
    serve_tx(200);
    exp_pack++;
    check("t4_done_latency", first_tick_cyc - done_cyc, 2);
    check("t4_pack_cnt", o_pack_cnt, exp_pack);

    // 5: frame C stalls (set won), then overrun byte 55 during its replay
    fill_rand();
    base = n_ticks;
    send_frame(calc_csum(), 1'b1);
    step(20);
    check("t5_set_wins_stall", n_ticks, base);
    pulse_done();
    k = 0;
    while ((n_ticks < base + 2) && (k < 200)) begin
      step(1);
      k++;
    end
    check("t5_replay_started", n_ticks >= base + 2, 1);
    send_byte(8'h55);
    serve_tx(200);
    exp_err++;
    exp_pack++;
    check("t5_overrun_err", o_err_cnt, exp_err);
    check("t5_pack_cnt", o_pack_cnt, exp_pack);
    pulse_done();
    send_byte(8'h00);
    send_byte(8'hFF);
    step(2);
    check("t5_idle_bytes_err", o_err_cnt, exp_err);
    check("t5_idle_bytes_state", o_dbg_state, ST_IDLE);

    // 6: reset at payload byte 5 aborts silently
    fill_seq();
    base = n_ticks;
    send_byte(SOF);
    for (int i = 0; i < 5; i++) send_byte(pl[i]);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_zero_outputs("t6_rst");
    exp_err = 0;
    exp_pack = 0;
    step(TIMEOUT + 10);
    check("t6_no_tx", tx_cnt, tx_served);
    check("t6_no_replay", n_ticks, base);
    check("t6_state_idle", o_dbg_state, ST_IDLE);
    send_frame(calc_csum(), 1'b1);
    serve_tx(200);
    exp_pack++;
    check("t6_pack_cnt", o_pack_cnt, exp_pack);
    check("t6_err_cnt", o_err_cnt, exp_err);
    check("t6_latency", first_tick_cyc - cs_cyc, 2);

    step(5);
    check("end_data_q_empty", exp_data_q.size(), 0);
    check("end_tx_q_empty", exp_tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
